// File: rtl/ls_unit_pkg.sv
// Shared load/store definitions: opcodes, tag/data bus widths, idle bus values and opcode helpers.
// Pure declarations, no latency or backpressure of its own.
package ls_unit_pkg;

   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;
   localparam int OP_W   = 3;

   localparam logic [TAG_W-1:0]  TAG_FREE  = 5'b10000;
   localparam logic [DATA_W-1:0] DATA_FREE = 32'h0000_0000;

   typedef enum logic [OP_W-1:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd3,
      LHU = 3'd4,
      SB  = 3'd5,
      SH  = 3'd6,
      SW  = 3'd7
   } op_t;

   function automatic logic [2:0] op_beats(input op_t op);
      case (op)
         LB, LBU, SB: return 3'd1;
         LH, LHU, SH: return 3'd2;
         default:     return 3'd4;
      endcase
   endfunction

   function automatic logic op_is_store(input op_t op);
      return (op == SB) || (op == SH) || (op == SW);
   endfunction

   function automatic logic op_misaligned(input op_t op, input logic [31:0] addr);
      case (op)
         LH, LHU, SH: return addr[0];
         LW, SW:      return |addr[1:0];
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ls_unit_if.sv
// Request, result-broadcast and byte-wide memory signals of the load/store unit (lsErr only with LS_MISALIGN_CHECK_EN).
// master = buffer/memory side, slave = ls_unit.
interface ls_unit_if;
   import ls_unit_pkg::*;

   logic              LSworkEn;
   logic [31:0]       operandO;
   logic [31:0]       operandT;
   logic [31:0]       imm;
   logic [TAG_W-1:0]  wrtTag;
   op_t               opCode;
   logic              LSreadEn;
   logic              LSdone;
   logic              enLSwrt;
   logic [TAG_W-1:0]  LStag;
   logic [31:0]       LSdata;
   logic              memReq;
   logic              memWe;
   logic [31:0]       memAddr;
   logic [7:0]        memWdata;
   logic              memStall;
   logic [7:0]        memRdata;
`ifdef LS_MISALIGN_CHECK_EN
   logic              lsErr;
`endif

   modport master (
      output LSworkEn, operandO, operandT, imm, wrtTag, opCode, memStall, memRdata,
      input  LSreadEn, LSdone, enLSwrt, LStag, LSdata, memReq, memWe, memAddr, memWdata
`ifdef LS_MISALIGN_CHECK_EN
      , input lsErr
`endif
   );

   modport slave (
      input  LSworkEn, operandO, operandT, imm, wrtTag, opCode, memStall, memRdata,
      output LSreadEn, LSdone, enLSwrt, LStag, LSdata, memReq, memWe, memAddr, memWdata
`ifdef LS_MISALIGN_CHECK_EN
      , output lsErr
`endif
   );

endinterface

// File: rtl/ls_unit_load_ext.sv
// Assembles captured little-endian bytes into a load result with sign/zero extension.
// Purely combinational; no backpressure.
module ls_load_ext
   import ls_unit_pkg::*;
(
   input  op_t             op,
   input  logic [3:0][7:0] bytes,
   output logic [31:0]     value
);

   logic [31:0] raw;

   assign raw = bytes;

   always_comb begin
      value = raw;
      case (op)
         LB:      value = {{24{raw[7]}}, raw[7:0]};
         LH:      value = {{16{raw[15]}}, raw[15:0]};
         LBU:     value = {24'h0, raw[7:0]};
         LHU:     value = {16'h0, raw[15:0]};
         default: value = raw;
      endcase
   end

endmodule

// File: rtl/ls_unit.sv
// Byte-serial load/store unit: n beats, loads done at accept+n+2, stores at accept+n+1, +1 per memStall cycle.
// One request in flight, LSreadEn low while busy; optional LS_MISALIGN_CHECK_EN rejects misaligned accesses.
module ls_unit
   import ls_unit_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   ls_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, TAIL, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [31:0]       addr_q;
   logic [31:0]       wdat_q;
   logic [TAG_W-1:0]  tag_q;
   op_t               op_q;
   logic [1:0]        beat_q;
   logic [3:0][7:0]   rbyte_q;
   logic              cap_q;
   logic [1:0]        cap_idx_q;
   logic [31:0]       req_addr;
   logic              accept;
   logic              beat_ok;
   logic              last_beat;
   logic              is_load_q;
   logic              mis_req;
   logic              err_now;
   logic [31:0]       load_val;

   assign req_addr  = bus.operandO + bus.imm;
   assign accept    = (state == IDLE) && bus.LSworkEn;
   assign beat_ok   = (state == ACCESS) && !bus.memStall;
   assign last_beat = ({1'b0, beat_q} == (op_beats(op_q) - 3'd1));
   assign is_load_q = !op_is_store(op_q);

`ifdef LS_MISALIGN_CHECK_EN
   logic err_q;

   assign mis_req = op_misaligned(bus.opCode, req_addr);
   assign err_now = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= mis_req;
      end
   end
`else
   assign mis_req = 1'b0;
   assign err_now = 1'b0;
`endif

   ls_load_ext u_ext (
      .op    (op_q),
      .bytes (rbyte_q),
      .value (load_val)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bus.LSreadEn = 1'b0;
      bus.LSdone   = 1'b0;
      bus.enLSwrt  = 1'b0;
      bus.LStag    = TAG_FREE;
      bus.LSdata   = DATA_FREE;
      bus.memReq   = 1'b0;
      bus.memWe    = 1'b0;
      bus.memAddr  = 32'h0;
      bus.memWdata = 8'h0;
`ifdef LS_MISALIGN_CHECK_EN
      bus.lsErr    = 1'b0;
`endif
      case (state)
         IDLE: begin
            bus.LSreadEn = !bus.LSworkEn;
            if (bus.LSworkEn) begin
               state_nxt = mis_req ? DONE : ACCESS;
            end
         end
         ACCESS: begin
            bus.memReq   = 1'b1;
            bus.memWe    = !is_load_q;
            bus.memAddr  = addr_q + {30'h0, beat_q};
            bus.memWdata = wdat_q[{beat_q, 3'b000} +: 8];
            if (beat_ok && last_beat) begin
               state_nxt = is_load_q ? TAIL : DONE;
            end
         end
         TAIL: begin
            state_nxt = DONE;
         end
         DONE: begin
            bus.LSdone = 1'b1;
`ifdef LS_MISALIGN_CHECK_EN
            bus.lsErr  = err_now;
`endif
            if (is_load_q && !err_now) begin
               bus.enLSwrt = 1'b1;
               bus.LStag   = tag_q;
               bus.LSdata  = load_val;
            end
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Read data trails its accepted beat by one cycle, so the byte lane is remembered in cap_idx_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q    <= 32'h0;
         wdat_q    <= 32'h0;
         tag_q     <= '0;
         op_q      <= LB;
         beat_q    <= 2'd0;
         rbyte_q   <= '0;
         cap_q     <= 1'b0;
         cap_idx_q <= 2'd0;
      end else begin
         cap_q     <= beat_ok && is_load_q;
         cap_idx_q <= beat_q;
         if (cap_q) begin
            rbyte_q[cap_idx_q] <= bus.memRdata;
         end
         if (accept) begin
            addr_q <= req_addr;
            wdat_q <= bus.operandT;
            tag_q  <= bus.wrtTag;
            op_q   <= bus.opCode;
            beat_q <= 2'd0;
         end else if (beat_ok) begin
            beat_q <= beat_q + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_ls_unit.sv
// Bench for ls_unit: directed vector table, reset-abort sequence and randomized ops against a byte-memory model.
// Memory responder returns the read byte one cycle after each accepted beat and can inject stalls.
module tb_ls_unit;
   import ls_unit_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   stall_cnt = 0;
   bit   rand_stall = 1'b0;

   typedef struct {
      int          cyc;
      logic [31:0] addr;
      logic        we;
      logic [7:0]  wd;
   } beat_t;

   typedef struct {
      int               cyc;
      logic             en;
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      logic             err;
   } done_t;

   typedef struct {
      op_t              op;
      logic [31:0]      opo;
      logic [31:0]      opt;
      logic [31:0]      imm;
      logic [31:0]      memw;
      logic [TAG_W-1:0] tag;
      logic [7:0]       stall;
      int               lat;
      logic [31:0]      data;
   } vec_t;

   beat_t      beats[$];
   done_t      dones[$];
   logic [7:0] mem [logic [31:0]];
   bit         stall_at [int];
   vec_t       tbl [12];

   ls_unit_if bus();

   ls_unit u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   function automatic int nbytes(input op_t op);
      case (op)
         LB, LBU, SB: return 1;
         LH, LHU, SH: return 2;
         default:     return 4;
      endcase
   endfunction

   function automatic bit is_store(input op_t op);
      return (op == SB) || (op == SH) || (op == SW);
   endfunction

   function automatic bit misaligned(input op_t op, input logic [31:0] a);
`ifdef LS_MISALIGN_CHECK_EN
      return (nbytes(op) == 2 && (a % 2) != 0) || (nbytes(op) == 4 && (a % 4) != 0);
`else
      return (op == LB) && (a != a);
`endif
   endfunction

   function automatic logic [7:0] mem_get(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = 8'($urandom);
      return mem[a];
   endfunction

   // Little-endian value of n bytes, then two's-complement reinterpretation for the signed loads.
   function automatic logic [31:0] ref_load(input op_t op, input logic [31:0] a);
      longint v;
      int     n;
      v = 0;
      n = nbytes(op);
      for (int k = 0; k < n; k++) v += longint'(mem_get(a + 32'(k))) << (8 * k);
      if ((op == LB || op == LH) && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      return v[31:0];
   endfunction

   // Monitor: logs accepted beats and done pulses, checks stall hold and idle output values.
   initial begin
      bit          hold;
      logic [31:0] h_addr;
      logic [7:0]  h_wd;
      logic        h_we;
      done_t       d;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            hold = 1'b0;
            continue;
         end
         if (hold) begin
            check("stall_hold_addr", bus.memAddr, h_addr);
            check("stall_hold_beat", 32'({bus.memReq, bus.memWe, bus.memWdata}), 32'({1'b1, h_we, h_wd}));
         end
         hold = 1'b0;
         if (bus.memReq) begin
            if (bus.memStall) begin
               stall_cnt++;
               hold = 1'b1;
               h_addr = bus.memAddr;
               h_wd = bus.memWdata;
               h_we = bus.memWe;
            end else begin
               beats.push_back(beat_t'{cyc, bus.memAddr, bus.memWe, bus.memWdata});
            end
         end else begin
            check("mem_quiet", 32'(bus.memWe), 32'h0);
         end
         if (bus.LSdone) begin
            d.cyc = cyc;
            d.en = bus.enLSwrt;
            d.tag = bus.LStag;
            d.data = bus.LSdata;
`ifdef LS_MISALIGN_CHECK_EN
            d.err = bus.lsErr;
`else
            d.err = 1'b0;
`endif
            dones.push_back(d);
         end else begin
            check("quiet_ctl", 32'({bus.enLSwrt, bus.LStag}), 32'({1'b0, TAG_FREE}));
            check("quiet_data", bus.LSdata, DATA_FREE);
`ifdef LS_MISALIGN_CHECK_EN
            check("quiet_err", 32'(bus.lsErr), 32'h0);
`endif
         end
      end
   end

   // Memory responder: data for a beat accepted in cycle c is presented throughout cycle c+1.
   initial begin
      bit          pend;
      logic [31:0] pa;
      bus.memStall = 1'b0;
      bus.memRdata = 8'h0;
      forever begin
         @(negedge clk);
         pend = rst && bus.memReq && !bus.memStall && !bus.memWe;
         pa = bus.memAddr;
         @(posedge clk);
         #1;
         bus.memRdata = pend ? mem_get(pa) : 8'($urandom);
         bus.memStall = stall_at.exists(cyc) || (rand_stall && $urandom_range(0, 3) == 0);
      end
   end

   task automatic run_op(input op_t op, input logic [31:0] opo, input logic [31:0] opt,
                         input logic [31:0] imm, input logic [TAG_W-1:0] tag,
                         input logic [7:0] stall_rel, output int lat, output logic [31:0] data);
      int          t, nb0, nd0, st0, n, guard, exp_lat;
      logic [31:0] a, exp_data;
      bit          mis, ld;
      done_t       d;
      beat_t       b;
      lat = -1;
      data = 32'hxxxx_xxxx;
      guard = 0;
      @(negedge clk);
      while (!bus.LSreadEn && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.LSreadEn) begin
         fail_now("readen_wait");
         return;
      end
      @(posedge clk);
      #1;
      bus.LSworkEn = 1'b1;
      bus.operandO = opo;
      bus.operandT = opt;
      bus.imm = imm;
      bus.wrtTag = tag;
      bus.opCode = op;
      t = cyc;
      nb0 = beats.size();
      nd0 = dones.size();
      st0 = stall_cnt;
      for (int i = 0; i < 8; i++) if (stall_rel[i]) stall_at[t + i] = 1'b1;
      @(negedge clk);
      check("readen_accept", 32'(bus.LSreadEn), 32'h0);
      @(posedge clk);
      #1;
      bus.LSworkEn = 1'b0;
      bus.operandO = $urandom;
      bus.operandT = $urandom;
      bus.imm = $urandom;
      bus.wrtTag = TAG_W'($urandom);
      bus.opCode = op_t'($urandom_range(0, 7));
      guard = 0;
      while (dones.size() == nd0 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      if (dones.size() == nd0) begin
         fail_now("done_wait");
         return;
      end
      d = dones[nd0];
      a = opo + imm;
      ld = !is_store(op);
      mis = misaligned(op, a);
      n = mis ? 0 : nbytes(op);
      lat = d.cyc - t;
      data = d.data;
      check("beat_count", beats.size() - nb0, n);
      for (int k = 0; k < n && nb0 + k < beats.size(); k++) begin
         b = beats[nb0 + k];
         check("beat_addr", b.addr, a + 32'(k));
         check("beat_we", 32'(b.we), 32'(!ld));
         if (!ld) check("beat_wdata", 32'(b.wd), (opt >> (8 * k)) & 32'hff);
         if (stall_cnt == st0) check("beat_cycle", b.cyc - t, k + 1);
      end
      exp_lat = mis ? 1 : n + (ld ? 2 : 1) + (stall_cnt - st0);
      check("latency", lat, exp_lat);
      check("done_en", 32'(d.en), 32'(ld && !mis));
      check("done_tag", 32'(d.tag), 32'((ld && !mis) ? tag : TAG_FREE));
      exp_data = (ld && !mis) ? ref_load(op, a) : DATA_FREE;
      check("done_data", d.data, exp_data);
      check("done_err", 32'(d.err), 32'(mis));
      if (!ld && !mis) for (int k = 0; k < n; k++) mem[a + 32'(k)] = opt[8 * k +: 8];
   endtask

   initial begin
      #1000000;
      total++;
      bad++;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat, xl, guard, t, nd0;
      logic [31:0] data, xd, a;

      //             op   operandO      operandT      imm           mem@addr      tag  stall  lat data
      tbl[0]  = '{LW,  32'h0000_0100, 32'h0,        32'h4,        32'h1234_5678, 5'd3, 8'h00, 6, 32'h1234_5678};
      tbl[1]  = '{LB,  32'h0000_0200, 32'h0,        32'h0,        32'h0000_0080, 5'd5, 8'h00, 3, 32'hFFFF_FF80};
      tbl[2]  = '{LBU, 32'h0000_0200, 32'h0,        32'h0,        32'h0000_0080, 5'd6, 8'h00, 3, 32'h0000_0080};
      tbl[3]  = '{LH,  32'h0000_03F0, 32'h0,        32'h10,       32'h0000_F234, 5'd7, 8'h00, 4, 32'hFFFF_F234};
      tbl[4]  = '{LHU, 32'h0000_03F0, 32'h0,        32'h10,       32'h0000_F234, 5'd8, 8'h00, 4, 32'h0000_F234};
      tbl[5]  = '{SH,  32'h0000_0300, 32'h0000_ABCD, 32'h1,       32'h0,         5'd9, 8'h00, 3, DATA_FREE};
      tbl[6]  = '{SB,  32'h0000_0500, 32'h1122_3344, 32'hFFFF_FFFF, 32'h0,       5'd1, 8'h00, 2, DATA_FREE};
      tbl[7]  = '{SW,  32'h0000_0600, 32'hCAFE_F00D, 32'h0,       32'h0,         5'd2, 8'h00, 5, DATA_FREE};
      tbl[8]  = '{LW,  32'h0000_0100, 32'h0,        32'h4,        32'h1234_5678, 5'd3, 8'h0C, 8, 32'h1234_5678};
      tbl[9]  = '{LW,  32'h0000_0100, 32'h0,        32'h2,        32'hDDCC_BBAA, 5'd4, 8'h00, 6, 32'hDDCC_BBAA};
      tbl[10] = '{LB,  32'hFFFF_FFFF, 32'h0,        32'h2,        32'h0000_007F, 5'd10, 8'h00, 3, 32'h0000_007F};
      tbl[11] = '{LH,  32'h0000_0700, 32'h0,        32'h0,        32'h0000_7FFF, 5'd11, 8'h00, 4, 32'h0000_7FFF};

      bus.LSworkEn = 1'b0;
      bus.operandO = 32'h0;
      bus.operandT = 32'h0;
      bus.imm = 32'h0;
      bus.wrtTag = '0;
      bus.opCode = LB;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctl", 32'({bus.LSdone, bus.enLSwrt, bus.memReq, bus.memWe}), 32'h0);
      check("rst_tag", 32'(bus.LStag), 32'(TAG_FREE));
      check("rst_data", bus.LSdata, DATA_FREE);
      check("rst_addr", bus.memAddr, 32'h0);
      check("rst_wdata", 32'(bus.memWdata), 32'h0);
`ifdef LS_MISALIGN_CHECK_EN
      check("rst_err", 32'(bus.lsErr), 32'h0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("readen_after_rst", 32'(bus.LSreadEn), 32'h1);

      for (int i = 0; i < 12; i++) begin
         a = tbl[i].opo + tbl[i].imm;
         for (int k = 0; k < 4; k++) mem[a + 32'(k)] = tbl[i].memw[8 * k +: 8];
         xl = tbl[i].lat;
         xd = tbl[i].data;
         if (misaligned(tbl[i].op, a)) begin
            xl = 1;
            xd = DATA_FREE;
         end
         run_op(tbl[i].op, tbl[i].opo, tbl[i].opt, tbl[i].imm, tbl[i].tag, tbl[i].stall, lat, data);
         check($sformatf("vec%0d_lat", i), lat, xl);
         check($sformatf("vec%0d_data", i), data, xd);
      end

      // Reset in the middle of a store: the bus must go quiet at once and no completion may follow.
      guard = 0;
      @(negedge clk);
      while (!bus.LSreadEn && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.LSreadEn) fail_now("abort_readen_wait");
      @(posedge clk);
      #1;
      bus.LSworkEn = 1'b1;
      bus.opCode = SW;
      bus.operandO = 32'h0000_0800;
      bus.operandT = 32'h5566_7788;
      bus.imm = 32'h0;
      bus.wrtTag = 5'd12;
      t = cyc;
      nd0 = dones.size();
      @(posedge clk);
      #1;
      bus.LSworkEn = 1'b0;
      @(posedge clk);
      #1;
      check("abort_cycle", cyc - t, 2);
      check("abort_req_before", 32'({bus.memReq, bus.memWe}), 32'h3);
      check("abort_addr_before", bus.memAddr, 32'h0000_0801);
      rst = 1'b0;
      #1;
      check("abort_req", 32'({bus.memReq, bus.memWe}), 32'h0);
      check("abort_addr", bus.memAddr, 32'h0);
      check("abort_done", 32'(bus.LSdone), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("abort_readen", 32'(bus.LSreadEn), 32'h1);
      repeat (5) @(negedge clk);
      check("abort_no_done", dones.size() - nd0, 0);

      rand_stall = 1'b1;
      for (int i = 0; i < 80; i++) begin
         run_op(op_t'($urandom_range(0, 7)), 32'h0000_1000 + 32'($urandom_range(0, 63)), $urandom,
                32'($urandom_range(0, 15)), TAG_W'($urandom_range(0, 15)), 8'h00, lat, data);
      end
      rand_stall = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ls_unit.md
LS_UNIT -- requirements
Module: ls_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 LSworkEn  in  1  request valid from load/store buffer; operands below are valid while it is high.
REQ-004 operandO / operandT / imm  in  32 each  base address / store data / offset.
REQ-005 wrtTag  in  `TagBus  destination tag; opCode  in  `OpBus  one of LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-006 LSreadEn  out  1  unit can accept a request issued next cycle.
REQ-007 LSdone  out  1  one-cycle completion pulse.
REQ-008 enLSwrt / LStag / LSdata  out  1 / `TagBus / 32  load result broadcast.
REQ-009 memReq / memWe / memAddr / memWdata  out  1 / 1 / 32 / 8  byte-wide memory request.
REQ-010 memStall  in  1  memory refuses the current beat; memRdata  in  8  read byte.
REQ-011 lsErr  out  1  misaligned-access flag; present only with LS_MISALIGN_CHECK_EN.

Function
REQ-012 LSreadEn SHALL be (state==IDLE) & ~LSworkEn, combinational; it is low in the accept cycle so the buffer never issues into a busy unit.
REQ-013 In IDLE, LSworkEn=1 SHALL latch the operands and compute address = operandO+imm, mod 2^32; the next state is ACCESS.
REQ-014 Beat count SHALL be 1 for byte ops, 2 for halfword ops and 4 for word ops; beat k uses address+k (little-endian, ascending).
REQ-015 ACCESS SHALL drive memReq=1 with memWe=1 for stores; a beat is accepted when memReq & ~memStall; addr/data are held unchanged while stalled.
REQ-016 Store data byte k SHALL be operandT[8k+7:8k].
REQ-017 Read byte for a beat accepted in cycle c SHALL be captured from memRdata in cycle c+1 regardless of memStall.
REQ-018 After the last accepted beat, loads SHALL go to TAIL (capture last byte) then DONE; stores SHALL go directly to DONE.
REQ-019 DONE SHALL last one cycle with LSdone=1; for loads it also drives enLSwrt=1, LStag=latched tag and LSdata=assembled value; the next state is IDLE.
REQ-020 LB/LH results SHALL be sign-extended from bit 7/15; LBU/LHU results SHALL be zero-extended.
REQ-021 Latency with no stall, accept at T: memReq in T+1..T+n; loads complete at T+n+2, stores at T+n+1; each stalled cycle adds one.
REQ-022 Outside DONE, enLSwrt=0, LStag=`tagFree and LSdata=`dataFree; outside ACCESS, memReq=0 and memWe=0.
REQ-023 Requests are non-speculative by construction (branch tags cleared upstream); the unit has no flush input.

Reset
REQ-024 rst low SHALL immediately force IDLE, clear all registers and abandon any in-flight access; outputs are LSdone=0, enLSwrt=0, memReq=0, memWe=0, LStag=`tagFree, LSdata=`dataFree, memAddr=0, memWdata=0, lsErr=0.
REQ-025 LSreadEn SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-026 Macro LS_MISALIGN_CHECK_EN: when defined, an LH/LHU/SH with address[0]!=0, or an LW/SW with address[1:0]!=0, SHALL issue no beats; it goes IDLE->DONE with LSdone=1, lsErr=1, enLSwrt=0.
REQ-027 When LS_MISALIGN_CHECK_EN is undefined, lsErr does not exist and misaligned accesses SHALL proceed byte-wise as normal.

Structure
REQ-028 Opcodes, `TagBus, `OpBus, `DataBus, `tagFree and `dataFree SHALL come from the shared defines.v; the FSM state encoding is local.
REQ-029 A single sub-module ls_load_ext SHALL perform the combinational byte assembly and sign/zero extension.

Verification
REQ-030 LW, operandO=0x100, imm=4, memory 0x104..0x107 = 78 56 34 12, tag 3, accept T -> beats T+1..T+4; enLSwrt, LSdone, LStag=3, LSdata=0x12345678 at T+6.
REQ-031 LB at 0x200 holding 0x80 -> LSdata=0xFFFFFF80; LBU at the same address -> 0x00000080; both complete at T+3.
REQ-032 SH, operandT=0x0000ABCD, address 0x301, no check macro -> beats (0x301, CD) at T+1 and (0x302, AB) at T+2; LSdone at T+3; enLSwrt stays 0.
REQ-033 LW with memStall=1 at T+2 and T+3 -> memAddr held at 0x105 during the stall; LSdone at T+8 with the correct data.
REQ-034 With LS_MISALIGN_CHECK_EN, LW at 0x102 -> no memReq; LSdone=1 and lsErr=1 at T+1. Without the macro, the same access completes at T+6.
REQ-035 LSworkEn arrives in the cycle after LSreadEn=1 -> LSreadEn=0 that cycle; rst pulled low at T+2 of an SW -> memReq drops immediately, LSdone never asserts, LSreadEn=1 after release.
